// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the load unit, the ALU and the regfile write-port arbiter.
// The master modport is the requester side; the slave modport is the arbiter.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
);
    logic                  mem_valid;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_data;
    logic                  mem_ready;
    logic                  alu_valid;
    logic [ADDR_W-1:0]     alu_addr;
    logic [DATA_W-1:0]     alu_data;
    logic                  alu_ready;
    logic                  write;
    logic [ADDR_W-1:0]     w_addr;
    logic [DATA_W-1:0]     d_in;
    logic [2**ADDR_W-1:0]  busy_mask;

    modport master (
        output mem_valid, mem_addr, mem_data,
        output alu_valid, alu_addr, alu_data,
        input  mem_ready, alu_ready,
        input  write, w_addr, d_in, busy_mask
    );

    modport slave (
        input  mem_valid, mem_addr, mem_data,
        input  alu_valid, alu_addr, alu_data,
        output mem_ready, alu_ready,
        output write, w_addr, d_in, busy_mask
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile's single write port between the load unit and the ALU.
// ALU writes that lose arbitration wait in a small FIFO; loads never overtake a queued write to the same register.
module regfile_wb_arbiter #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 5,
    parameter int Q_DEPTH = 2
) (
    input logic                 clk,
    input logic                 reset,
    regfile_wb_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(Q_DEPTH);
    localparam int CNT_W = $clog2(Q_DEPTH + 1);
    localparam int NREG  = 2**ADDR_W;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_QUEUE,
        SRC_MEM,
        SRC_ALU
    } src_t;

    logic [ADDR_W-1:0]  q_addr [Q_DEPTH];
    logic [DATA_W-1:0]  q_data [Q_DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;
    logic [Q_DEPTH-1:0] slot_valid;
    logic [PTR_W-1:0]   slot_off;

    logic               q_full;
    logic               q_empty;
    logic               mem_hit;
    logic               mem_ready;
    logic               alu_ready;
    logic               mem_go;
    logic               alu_go;
    logic               enq;
    logic               deq;
    src_t               sel;

    logic               write_q;
    logic [ADDR_W-1:0]  w_addr_q;
    logic [DATA_W-1:0]  d_in_q;
    logic [NREG-1:0]    busy;

    assign q_full  = (count == CNT_W'(Q_DEPTH));
    assign q_empty = (count == '0);

    // Occupancy is derived from head/count, so stale slots are never looked at.
    always_comb begin
        slot_valid = '0;
        slot_off   = '0;
        mem_hit    = 1'b0;
        busy       = '0;
        for (int i = 0; i < Q_DEPTH; i++) begin
            slot_off      = PTR_W'(i) - head;
            slot_valid[i] = (CNT_W'(slot_off) < count);
            if (slot_valid[i]) begin
                busy[q_addr[i]] = 1'b1;
                if (q_addr[i] == bus.mem_addr) begin
                    mem_hit = 1'b1;
                end
            end
        end
        if (write_q) begin
            busy[w_addr_q] = 1'b1;
        end
    end

    assign mem_ready = !reset && !q_full && !mem_hit;
    assign alu_ready = !reset && !q_full;
    assign mem_go    = bus.mem_valid && mem_ready;
    assign alu_go    = bus.alu_valid && alu_ready;

    always_comb begin
        sel = SRC_NONE;
        deq = 1'b0;
        enq = 1'b0;
        if (q_full) begin
            sel = SRC_QUEUE;
            deq = 1'b1;
        end else if (mem_go) begin
            sel = SRC_MEM;
        end else if (!q_empty) begin
            sel = SRC_QUEUE;
            deq = 1'b1;
        end else if (alu_go) begin
            sel = SRC_ALU;
        end
        enq = alu_go && (sel != SRC_ALU);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            write_q  <= 1'b0;
            w_addr_q <= '0;
            d_in_q   <= '0;
        end else begin
            if (enq) begin
                tail <= tail + PTR_W'(1);
            end
            if (deq) begin
                head <= head + PTR_W'(1);
            end
            count   <= count + CNT_W'(enq) - CNT_W'(deq);
            write_q <= (sel != SRC_NONE);
            case (sel)
                SRC_QUEUE: begin
                    w_addr_q <= q_addr[head];
                    d_in_q   <= q_data[head];
                end
                SRC_MEM: begin
                    w_addr_q <= bus.mem_addr;
                    d_in_q   <= bus.mem_data;
                end
                SRC_ALU: begin
                    w_addr_q <= bus.alu_addr;
                    d_in_q   <= bus.alu_data;
                end
                default: begin
                    w_addr_q <= w_addr_q;
                    d_in_q   <= d_in_q;
                end
            endcase
        end
    end

    // Entry storage needs no reset: count alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_addr[tail] <= bus.alu_addr;
            q_data[tail] <= bus.alu_data;
        end
    end

    assign bus.mem_ready = mem_ready;
    assign bus.alu_ready = alu_ready;
    assign bus.write     = write_q;
    assign bus.w_addr    = w_addr_q;
    assign bus.d_in      = d_in_q;
    assign bus.busy_mask = busy;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for the regfile writeback arbiter: arbitration order, FIFO order,
// same-register load blocking, busy mask and reset behaviour.
module tb_regfile_wb_arbiter;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 5;
    localparam int Q_DEPTH = 2;

    logic clk = 1'b0;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;

    regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_wb_arbiter #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .Q_DEPTH(Q_DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic mv, input logic [4:0] ma, input logic [15:0] md,
                         input logic av, input logic [4:0] aa, input logic [15:0] ad);
        bus.mem_valid = mv;
        bus.mem_addr  = ma;
        bus.mem_data  = md;
        bus.alu_valid = av;
        bus.alu_addr  = aa;
        bus.alu_data  = ad;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rdy(input string tag, input logic mr, input logic ar);
        #1;
        check({tag, ".mem_ready"}, 32'(bus.mem_ready), 32'(mr));
        check({tag, ".alu_ready"}, 32'(bus.alu_ready), 32'(ar));
    endtask

    task automatic chk_wr(input string tag, input logic w, input logic [4:0] wa, input logic [15:0] d);
        check({tag, ".write"},  32'(bus.write),  32'(w));
        check({tag, ".w_addr"}, 32'(bus.w_addr), 32'(wa));
        check({tag, ".d_in"},   32'(bus.d_in),   32'(d));
    endtask

    task automatic chk_busy(input string tag, input logic [31:0] mask);
        check({tag, ".busy"}, bus.busy_mask, mask);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with both sources requesting: nothing accepted, port idle
        reset = 1'b1;
        drive(1'b1, 5'd9, 16'h9999, 1'b1, 5'd9, 16'h9999);
        chk_rdy("rst_req", 1'b0, 1'b0);
        tick();
        chk_wr("rst_out", 1'b0, 5'd0, 16'h0000);
        chk_busy("rst_out", 32'h0);
        tick();
        chk_wr("rst_out2", 1'b0, 5'd0, 16'h0000);

        // Single ALU write goes direct
        reset = 1'b0;
        drive(1'b0, 5'd0, 16'h0000, 1'b1, 5'd21, 16'h0001);
        chk_rdy("alu1", 1'b1, 1'b1);
        tick();
        chk_wr("alu1_out", 1'b1, 5'd21, 16'h0001);
        chk_busy("alu1_out", 32'h1 << 21);
        idle();
        tick();
        chk_wr("alu1_hold", 1'b0, 5'd21, 16'h0001);
        chk_busy("alu1_hold", 32'h0);

        // Load and ALU together: load first, ALU from the queue next
        drive(1'b1, 5'd10, 16'h0002, 1'b1, 5'd3, 16'h0003);
        chk_rdy("both", 1'b1, 1'b1);
        tick();
        chk_wr("both_c1", 1'b1, 5'd10, 16'h0002);
        chk_busy("both_c1", (32'h1 << 10) | (32'h1 << 3));
        idle();
        tick();
        chk_wr("both_c2", 1'b1, 5'd3, 16'h0003);
        chk_busy("both_c2", 32'h1 << 3);
        tick();
        chk_wr("both_c3", 1'b0, 5'd3, 16'h0003);
        chk_busy("both_c3", 32'h0);

        // Continuous loads, ALU 1,2,3 back-to-back: fill, drain on full, FIFO order
        drive(1'b1, 5'd20, 16'h0114, 1'b1, 5'd1, 16'h0011);
        chk_rdy("burst_a", 1'b1, 1'b1);
        tick();
        chk_wr("burst_a_out", 1'b1, 5'd20, 16'h0114);
        chk_busy("burst_a_out", (32'h1 << 1) | (32'h1 << 20));
        drive(1'b1, 5'd21, 16'h0115, 1'b1, 5'd2, 16'h0012);
        chk_rdy("burst_b", 1'b1, 1'b1);
        tick();
        chk_wr("burst_b_out", 1'b1, 5'd21, 16'h0115);
        chk_busy("burst_b_out", (32'h1 << 1) | (32'h1 << 2) | (32'h1 << 21));
        drive(1'b1, 5'd22, 16'h0116, 1'b1, 5'd3, 16'h0013);
        chk_rdy("burst_c_full", 1'b0, 1'b0);
        tick();
        chk_wr("burst_c_out", 1'b1, 5'd1, 16'h0011);
        chk_busy("burst_c_out", (32'h1 << 1) | (32'h1 << 2));
        chk_rdy("burst_d", 1'b1, 1'b1);
        tick();
        chk_wr("burst_d_out", 1'b1, 5'd22, 16'h0116);
        chk_busy("burst_d_out", (32'h1 << 2) | (32'h1 << 3) | (32'h1 << 22));
        drive(1'b1, 5'd23, 16'h0117, 1'b0, 5'd0, 16'h0000);
        chk_rdy("burst_e_full", 1'b0, 1'b0);
        tick();
        chk_wr("burst_e_out", 1'b1, 5'd2, 16'h0012);
        chk_rdy("burst_f", 1'b1, 1'b1);
        tick();
        chk_wr("burst_f_out", 1'b1, 5'd23, 16'h0117);
        chk_busy("burst_f_out", (32'h1 << 3) | (32'h1 << 23));
        idle();
        tick();
        chk_wr("burst_g_out", 1'b1, 5'd3, 16'h0013);
        tick();
        chk_wr("burst_h_out", 1'b0, 5'd3, 16'h0013);
        chk_busy("burst_h_out", 32'h0);

        // Load to a register with a queued ALU write waits for that write
        drive(1'b1, 5'd12, 16'h0C0C, 1'b1, 5'd7, 16'h0707);
        chk_rdy("waw_a", 1'b1, 1'b1);
        tick();
        chk_wr("waw_a_out", 1'b1, 5'd12, 16'h0C0C);
        drive(1'b1, 5'd7, 16'h7777, 1'b0, 5'd0, 16'h0000);
        chk_rdy("waw_b_blocked", 1'b0, 1'b1);
        tick();
        chk_wr("waw_b_out", 1'b1, 5'd7, 16'h0707);
        chk_busy("waw_b_out", 32'h1 << 7);
        chk_rdy("waw_c", 1'b1, 1'b1);
        tick();
        chk_wr("waw_c_out", 1'b1, 5'd7, 16'h7777);
        idle();
        tick();
        chk_wr("waw_d_out", 1'b0, 5'd7, 16'h7777);

        // Fill the queue, then reset: queued writes are dropped
        drive(1'b1, 5'd14, 16'h0E0E, 1'b1, 5'd4, 16'h0404);
        chk_rdy("flush_a", 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd15, 16'h0F0F, 1'b1, 5'd5, 16'h0505);
        chk_rdy("flush_b", 1'b1, 1'b1);
        tick();
        chk_wr("flush_b_out", 1'b1, 5'd15, 16'h0F0F);
        chk_busy("flush_b_out", (32'h1 << 4) | (32'h1 << 5) | (32'h1 << 15));
        reset = 1'b1;
        drive(1'b1, 5'd16, 16'h1010, 1'b1, 5'd6, 16'h0606);
        chk_rdy("flush_rst", 1'b0, 1'b0);
        tick();
        chk_wr("flush_rst_out", 1'b0, 5'd0, 16'h0000);
        chk_busy("flush_rst_out", 32'h0);
        reset = 1'b0;
        idle();
        chk_rdy("flush_after", 1'b1, 1'b1);
        tick();
        chk_wr("flush_after1", 1'b0, 5'd0, 16'h0000);
        chk_busy("flush_after1", 32'h0);
        tick();
        chk_wr("flush_after2", 1'b0, 5'd0, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, register data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, register address width (32 registers).
REQ-003 The block SHALL have parameter Q_DEPTH, default 2, ALU deferral queue depth (power of two, >=2).
REQ-004 The block SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port mem_valid  input  1  load-unit writeback request.
REQ-007 The block SHALL have port mem_addr  input  ADDR_W  load destination register.
REQ-008 The block SHALL have port mem_data  input  DATA_W  load writeback data.
REQ-009 The block SHALL have port mem_ready  output  1  load request accepted this cycle.
REQ-010 The block SHALL have port alu_valid  input  1  ALU writeback request.
REQ-011 The block SHALL have port alu_addr  input  ADDR_W  ALU destination register.
REQ-012 The block SHALL have port alu_data  input  DATA_W  ALU writeback data.
REQ-013 The block SHALL have port alu_ready  output  1  ALU request accepted this cycle.
REQ-014 The block SHALL have port write  output  1  regfile write enable.
REQ-015 The block SHALL have port w_addr  output  ADDR_W  regfile write address.
REQ-016 The block SHALL have port d_in  output  DATA_W  regfile write data.
REQ-017 The block SHALL have port busy_mask  output  2**ADDR_W  bit i set while a write to register i is queued or staged.

Function
REQ-018 The block SHALL share the regfile's single write port between the load unit and the ALU; transfer occurs when valid && ready at a rising edge.
REQ-019 The block SHALL register write/w_addr/d_in: a request granted at edge N appears on the write port for exactly one cycle after edge N.
REQ-020 Grant order each cycle SHALL be: (1) queue head if queue full; (2) mem if mem_valid and not blocked; (3) queue head if queue non-empty; (4) ALU direct if queue empty and alu_valid.
REQ-021 mem_ready SHALL be 1 iff not in reset, queue not full, and mem_addr matches no queued entry address (WAW block).
REQ-022 alu_ready SHALL be 1 iff not in reset and queue not full.
REQ-023 An accepted ALU request not granted the port SHALL be enqueued at the tail; enqueue and dequeue in the same cycle SHALL leave count unchanged.
REQ-024 Queue SHALL be FIFO; ALU writes SHALL reach the regfile in acceptance order.
REQ-025 When no source is granted, write SHALL be 0 next cycle; w_addr/d_in SHALL hold previous values.
REQ-026 busy_mask SHALL be combinational from queue entries plus the staged output (write=1); duplicate addresses SHALL keep the bit set until the last such write leaves.
REQ-027 Queue pointers SHALL wrap modulo Q_DEPTH; count SHALL range 0..Q_DEPTH and never over/underflow.
REQ-028 A full queue SHALL always drain one entry per cycle, so alu_ready deasserts for at most one consecutive cycle from fullness alone.

Reset
REQ-029 While reset=1 at an edge: queue count and pointers 0, write=0, w_addr=0, d_in=0; mem_ready=alu_ready=0 during reset.
REQ-030 Reset mid-operation SHALL discard queued entries (no write issued for them) and clear busy_mask on the next cycle.

Verification
REQ-031 Reset, then alu_valid with addr=5'd21, data=16'h0001, mem idle -> alu_ready=1; next cycle write=1, w_addr=21, d_in=0x0001; busy_mask[21]=1 for that cycle only.
REQ-032 mem_valid (addr=10, data=0x0002) and alu_valid (addr=3, data=0x0003) same cycle -> both ready; write addr 10 next cycle, addr 3 the cycle after; queue then empty.
REQ-033 mem_valid held 4 cycles, ALU issuing addr 1,2,3 back-to-back -> third ALU request sees alu_ready=0 (queue full); queue head addr 1 wins over mem; write order 1,2,3 preserved.
REQ-034 ALU addr 7 queued behind mem traffic, then mem_valid addr 7 -> mem_ready=0 until addr-7 ALU write issues; mem write to 7 strictly follows.
REQ-035 Fill queue (2 entries), assert reset one cycle -> no writes for queued entries, busy_mask=0, ready outputs 0 during reset and 1 after.
